// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multi-cycle signed integer multiply/divide unit holding the
//            architectural HI/LO registers. Multiply is radix-2 shift-add,
//            divide is restoring; both run on operand magnitudes for WIDTH
//            cycles, then one fix-up cycle applies signs and writes HI/LO.
// Options  : `define MDU_UNSIGNED_EN adds the is_unsigned input (multu/divu).
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH          = 32,
  parameter int CONTROL_LENGTH = 4,
  parameter int MULT_CODE      = 10,
  parameter int DIV_CODE       = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CONTROL_LENGTH-1:0] control,
  input  logic                      start,
`ifdef MDU_UNSIGNED_EN
  input  logic                      is_unsigned,
`endif
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      hi_wr,
  input  logic                      lo_wr,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          hi,
  output logic [WIDTH-1:0]          lo
);

  localparam int                        c_CNT_W     = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0]        c_LAST      = c_CNT_W'(WIDTH - 1);
  localparam logic [CONTROL_LENGTH-1:0] c_MULT_CODE = CONTROL_LENGTH'(MULT_CODE);
  localparam logic [CONTROL_LENGTH-1:0] c_DIV_CODE  = CONTROL_LENGTH'(DIV_CODE);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_CNT_W-1:0] r_count;
  logic               r_op_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_mt_ok;
  logic               w_sign_a_in;
  logic               w_sign_b_in;
  logic [WIDTH-1:0]   w_mag_a_in;
  logic [WIDTH-1:0]   w_mag_b_in;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_a_orig;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand signs: unsigned operations simply treat both operands as positive.
`ifdef MDU_UNSIGNED_EN
  assign w_sign_a_in = a[WIDTH-1] & ~is_unsigned;
  assign w_sign_b_in = b[WIDTH-1] & ~is_unsigned;
`else
  assign w_sign_a_in = a[WIDTH-1];
  assign w_sign_b_in = b[WIDTH-1];
`endif

  assign w_mag_a_in = w_sign_a_in ? (~a + 1'b1) : a;
  assign w_mag_b_in = w_sign_b_in ? (~b + 1'b1) : b;

  assign w_accept = (r_state == c_IDLE) && start &&
                    ((control == c_MULT_CODE) || (control == c_DIV_CODE));
  // An accepted start takes the cycle; mthi/mtlo only land when truly idle.
  assign w_mt_ok  = (r_state == c_IDLE) && !w_accept;

  // Multiply step: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right, keeping the carry out of the add.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide step: remainder in the upper half, dividend/quotient in the lower.
  // Shift one dividend bit into the remainder and try subtracting the divisor.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mag_b};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction for the final HI/LO write.
  assign w_neg    = r_sign_a ^ r_sign_b;
  assign w_prod   = w_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quot   = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_a_orig = r_sign_a ? (~r_mag_a + 1'b1) : r_mag_a;

  // Result selection; divide-by-zero reports all-ones quotient and the dividend.
  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_op_div) begin
      if (r_mag_b == '0) begin
        w_fix_hi = w_a_orig;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_sign_a ? (~w_rem + 1'b1) : w_rem;
        w_fix_lo = w_neg ? (~w_quot + 1'b1) : w_quot;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_next = c_CALC;
      c_CALC:  if (r_count == c_LAST) w_state_next = c_FIX;
      c_FIX:   w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // Outputs: busy covers CALC and FIX; done is the registered write pulse.
  always_comb begin
    busy = (r_state != c_IDLE);
    done = r_done;
  end

  assign hi = r_hi;
  assign lo = r_lo;

  // Datapath: operand capture, iteration, result write and mthi/mtlo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_op_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op_div <= (control == c_DIV_CODE);
        r_sign_a <= w_sign_a_in;
        r_sign_b <= w_sign_b_in;
        r_mag_a  <= w_mag_a_in;
        r_mag_b  <= w_mag_b_in;
        r_count  <= '0;
        r_acc    <= {{WIDTH{1'b0}}, (control == c_DIV_CODE) ? w_mag_a_in : w_mag_b_in};
      end else if (r_state == c_CALC) begin
        r_acc   <= r_op_div ? w_div_next : w_mul_next;
        r_count <= r_count + 1'b1;
      end else if (r_state == c_FIX) begin
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
        r_done <= 1'b1;
      end
      if (w_mt_ok && hi_wr) r_hi <= wr_data;
      if (w_mt_ok && lo_wr) r_lo <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed self-checking bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  control = '0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .control (control),
    .start   (start),
    .a       (a),
    .b       (b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, take edge E0, drop start. Returns at E0 + 1.
  task automatic launch(input logic [3:0] ctrl, input logic [31:0] aa, input logic [31:0] bb);
    control = ctrl;
    a       = aa;
    b       = bb;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // Count edges after E0 until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic op_check(input string tag, input logic [3:0] ctrl,
                          input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    launch(ctrl, aa, bb);
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " hilo"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int cyc;
    int seen;
    logic [31:0] hi_prev;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed multiply, plus one-cycle done pulse
    op_check("mul -3*7", 4'd10, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    @(posedge clk);
    #1;
    check("done pulse width", 64'(done), 64'd0);
    check("busy after done", 64'(busy), 64'd0);

    // Signed divides
    op_check("div -7/2", 4'd11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_check("div 7/-2", 4'd11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

    // Boundaries (each launched in the previous done cycle: back-to-back)
    op_check("div by zero", 4'd11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    op_check("div overflow", 4'd11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    op_check("mul -1*-1", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);
    op_check("mul 0x10000*0x10000", 4'd10, 32'h00010000, 32'h00010000, 32'd1, 32'd0);
    op_check("div 100/7", 4'd11, 32'd100, 32'd7, 32'd2, 32'd14);

    // Start during busy is ignored
    launch(4'd10, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    launch(4'd10, 32'd100, 32'd100);
    wait_done(cyc);
    check("busy start latency", 64'(cyc), 64'd27);
    check("busy start result", {hi, lo}, {32'd0, 32'd15});
    @(posedge clk);
    #1;

    // Non-MDU control code in IDLE is ignored
    launch(4'd5, 32'd9, 32'd9);
    check("ctrl 5 busy", 64'(busy), 64'd0);

    // mtlo in IDLE
    lo_wr   = 1'b1;
    wr_data = 32'h0000CAFE;
    @(posedge clk);
    #1;
    lo_wr = 1'b0;
    check("mtlo", 64'(lo), 64'h0000CAFE);

    // mthi in IDLE, then mthi while busy
    hi_wr   = 1'b1;
    wr_data = 32'h00001111;
    @(posedge clk);
    #1;
    hi_wr = 1'b0;
    check("mthi", 64'(hi), 64'h00001111);
    hi_prev = hi;
    launch(4'd10, 32'd2, 32'd3);
    hi_wr   = 1'b1;
    wr_data = 32'hBEEF0000;
    @(posedge clk);
    #1;
    hi_wr = 1'b0;
    check("mthi while busy", 64'(hi), 64'(hi_prev));
    wait_done(cyc);
    check("mul 2*3", {hi, lo}, {32'd0, 32'd6});
    @(posedge clk);
    #1;

    // mthi with an accepted start in the same cycle is dropped
    hi_wr   = 1'b1;
    wr_data = 32'hDEADDEAD;
    launch(4'd10, 32'd4, 32'd5);
    hi_wr = 1'b0;
    check("mthi vs start", 64'(hi), 64'd0);
    wait_done(cyc);
    check("mul 4*5", {hi, lo}, {32'd0, 32'd20});
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    launch(4'd10, 32'd7, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst done", 64'(done), 64'd0);
    check("mid rst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("no done after rst", 64'(seen), 64'd0);
    check("hilo after rst", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit; executes the ALU control codes 10 (mult) and 11 (div).
- Holds the architectural HI/LO registers read by mfhi/mflo.
- Sits beside the combinational ALU in the execute stage. It raises busy so the datapath stalls until results land in HI/LO.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CONTROL_LENGTH, 4, width of the ALU control code input.
- MULT_CODE, 10, control value that starts a multiply.
- DIV_CODE, 11, control value that starts a divide.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- control  input  CONTROL_LENGTH  ALU control code from the ALU control decoder.
- start  input  1  request qualifier; operation begins only when start=1 and control is MULT_CODE or DIV_CODE.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- hi_wr  input  1  mthi write strobe.
- lo_wr  input  1  mtlo write strobe.
- wr_data  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in progress; the datapath stalls on this.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- hi  output  WIDTH  HI register (product high / remainder).
- lo  output  WIDTH  LO register (product low / quotient).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operands cleared. Reset mid-operation aborts it, and no result is written.
- States:
  - IDLE: accepts a start.
  - CALC: 32 iteration cycles.
  - FIX: one cycle for sign correction and the HI/LO write.
  - FIX always returns to IDLE.
- Start acceptance:
  - In IDLE, at edge E0 with start=1 and control in {MULT_CODE, DIV_CODE}, latch a, b, op and operand signs.
  - Take magnitudes of a and b (two's complement, signed), then go to CALC with counter=0.
  - Any other control value with start=1 is ignored.
- Timing:
  - busy=1 from after E0 through E33.
  - CALC runs edges E1..E32, one bit per edge.
  - At E33 (FIX), hi/lo load, done=1 for exactly one cycle, busy=0, state=IDLE.
  - A new start may be accepted at E34 (the done cycle counts as IDLE).
- Multiply:
  - Radix-2 shift-add on magnitudes into a 2*WIDTH accumulator.
  - In FIX, negate the 64-bit product if the signs of a and b differ.
  - {hi,lo} = 64-bit signed product.
- Divide:
  - Restoring divide on magnitudes.
  - In FIX, quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero (b=0): still takes the full 33 cycles. Result is lo=32'hFFFFFFFF and hi=a (original dividend, not the magnitude), with no sign fix.
- Overflow: a=32'h80000000, b=32'hFFFFFFFF gives lo=32'h80000000, hi=0.
- start while busy: ignored; operands are not re-latched.
- mthi/mtlo:
  - In IDLE, hi_wr/lo_wr write wr_data to hi/lo at the edge.
  - While busy they are ignored.
  - An accepted start in the same cycle wins, and the writes are dropped.
  - hi_wr and lo_wr together write both registers.
- hi/lo hold their value except on the FIX write, an mthi/mtlo write, or reset.

Optional Feature:
- Macro: MDU_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), sampled with start. When is_unsigned=1 there is no magnitude conversion or sign fix (multu/divu semantics). Divide by zero gives lo=32'hFFFFFFFF, hi=a.
- Undefined: no is_unsigned port; all operations are signed.

Test Plan:
- Reset: assert rst_n=0 mid-CALC of a multiply -> busy=0, done=0, hi=0, lo=0 immediately; no done pulse after release.
- Signed mult: a=-3 (32'hFFFFFFFD), b=7, control=10, start=1 -> busy high 33 cycles; then done pulse with hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- Signed div: a=-7, b=2, control=11 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Also a=7, b=-2 -> lo=-3, hi=1.
- Boundaries:
  - b=0 with a=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678.
  - a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
  - a=b=32'hFFFFFFFF mult -> hi=0, lo=1.
- Handshake:
  - start with control=10 during busy -> ignored, first result intact.
  - start with control=5 in IDLE -> busy stays 0.
  - Back-to-back start in the done cycle is accepted.
- mthi/mtlo:
  - lo_wr with wr_data=32'hCAFE in IDLE -> lo=32'hCAFE next cycle.
  - hi_wr while busy -> hi unchanged.
  - hi_wr together with an accepted start -> write dropped; hi equals the mult result.
